// File: rtl/benes_8_router.sv
// 8-lane Benes datapath: five pipelined columns of 2x2 switches driven by a
// guarded configuration register, with valid/ready streaming on the data path.
module benes_8_router #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           areset,
    input  logic           cfg_valid,
    input  logic [19:0]    cfg_state,
    output logic           cfg_ready,
    output logic           cfg_loaded,
    input  logic           in_valid,
    input  logic [8*W-1:0] in_data,
    output logic           in_ready,
    output logic           out_valid,
    output logic [8*W-1:0] out_data,
    input  logic           out_ready
);

    logic [19:0]               r_cfg;
    logic                      r_loaded;
    logic [4:0]                r_v;
    logic [4:0][7:0][W-1:0]    r_d;
    logic [4:0][7:0][W-1:0]    w_c;
    logic [4:0]                w_ld;
    logic [7:0][W-1:0]         w_in;

    // Returns {out1, out0}; s=1 passes straight, s=0 crosses.
    function automatic logic [2*W-1:0] sw2(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         s
    );
        return s ? {b, a} : {a, b};
    endfunction

    assign w_in = in_data;

    // Column 0 splits into upper/lower subnets; column 4 merges them.
    for (genvar m = 0; m < 4; m++) begin : g_edge
        assign {w_c[0][4+m], w_c[0][m]} =
            sw2(w_in[2*m], w_in[2*m+1], r_cfg[5*m]);
        assign {w_c[4][2*m+1], w_c[4][2*m]} =
            sw2(r_d[3][m], r_d[3][4+m], r_cfg[5*m+4]);
    end

    // Inner columns: each register is indexed by the next column's inputs.
    for (genvar u = 0; u < 2; u++) begin : g_sub
        for (genvar r = 0; r < 2; r++) begin : g_row
            localparam int M = 2*u + r;
            localparam int B = 4*u;
            assign {w_c[1][B+2+r], w_c[1][B+r]} =
                sw2(r_d[0][B+2*r], r_d[0][B+2*r+1], r_cfg[5*M+1]);
            assign {w_c[2][B+2+r], w_c[2][B+r]} =
                sw2(r_d[1][B+2*r], r_d[1][B+2*r+1], r_cfg[5*M+2]);
            assign {w_c[3][B+2*r+1], w_c[3][B+2*r]} =
                sw2(r_d[2][B+2*r], r_d[2][B+2*r+1], r_cfg[5*M+3]);
        end
    end

    always_comb begin
        w_ld    = '0;
        w_ld[4] = ~r_v[4] | out_ready;
        for (int k = 3; k >= 0; k--) begin
            w_ld[k] = ~r_v[k] | w_ld[k+1];
        end
    end

    assign cfg_ready  = cfg_valid & ~|r_v;
    assign cfg_loaded = r_loaded;
    assign in_ready   = r_loaded & ~cfg_valid & w_ld[0];
    assign out_valid  = r_v[4];
    assign out_data   = r_d[4];

    always_ff @(posedge clk) begin
        if (areset) begin
            r_v      <= '0;
            r_d      <= '0;
            r_cfg    <= 20'hFFFFF;
            r_loaded <= 1'b0;
        end else begin
            if (cfg_ready) begin
                r_cfg    <= cfg_state;
                r_loaded <= 1'b1;
            end
            if (w_ld[0]) begin
                r_v[0] <= in_valid & in_ready;
                r_d[0] <= w_c[0];
            end
            for (int k = 1; k < 5; k++) begin
                if (w_ld[k]) begin
                    r_v[k] <= r_v[k-1];
                    r_d[k] <= w_c[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_benes_8_router.sv
// Directed and randomised checks of the 8-lane Benes router against
// hand-computed words and a per-lane path-tracing permutation model.
module tb_benes_8_router;

    localparam logic [63:0] ID   = 64'h0706050403020100;
    localparam logic [63:0] SW01 = 64'h0706050403020001;
    localparam logic [63:0] PAIR = 64'h0607040502030001;

    logic        clk = 1'b0;
    logic        areset;
    logic        cfg_valid;
    logic [19:0] cfg_state;
    logic        cfg_ready;
    logic        cfg_loaded;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    benes_8_router #(.W(8)) dut (
        .clk        (clk),
        .areset     (areset),
        .cfg_valid  (cfg_valid),
        .cfg_state  (cfg_state),
        .cfg_ready  (cfg_ready),
        .cfg_loaded (cfg_loaded),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    function automatic logic [63:0] wd(input int k);
        return {8{k[7:0]}} ^ ID;
    endfunction

    // Trace each input lane through the network column by column.
    function automatic logic [63:0] route(
        input logic [19:0] c,
        input logic [63:0] d
    );
        logic [63:0] q;
        int m, p, o, u, idx, r, s;
        q = '0;
        for (int l = 0; l < 8; l++) begin
            m = l / 2; p = l % 2;
            o = c[5*m] ? p : 1 - p;
            u = o; idx = m;
            r = idx / 2; p = idx % 2; m = 2*u + r;
            o = c[5*m+1] ? p : 1 - p;
            s = o; p = r; m = 2*u + s;
            o = c[5*m+2] ? p : 1 - p;
            r = o; p = s; m = 2*u + r;
            o = c[5*m+3] ? p : 1 - p;
            idx = 2*r + o;
            m = idx; p = u;
            o = c[5*m+4] ? p : 1 - p;
            q[(2*m+o)*8 +: 8] = d[l*8 +: 8];
        end
        return q;
    endfunction

    task automatic load_cfg(input logic [19:0] c);
        int n;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_state = c;
        #1;
        n = 0;
        while (!cfg_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (!cfg_ready) begin
            errors++;
            $display("FAIL cfg_accept cfg=%h: cfg_ready=%b required 1", c, cfg_ready);
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic xfer(
        input  logic [63:0] d,
        output logic [63:0] q,
        output logic        ok
    );
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk); #1;
        while (!out_valid && n < 50) begin
            @(negedge clk); #1; n++;
        end
        ok = ok && out_valid;
        q  = out_data;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || cfg_loaded !== 1'b0 || in_ready !== 1'b0 ||
            cfg_ready !== 1'b0 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: ov=%b cl=%b ir=%b cr=%b od=%h required 0 0 0 0 0",
                     out_valid, cfg_loaded, in_ready, cfg_ready, out_data);
        end
        areset   = 1'b0;
        in_valid = 1'b1;
        in_data  = ID;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_cfg_block: in_ready=%b out_valid=%b required 0 0",
                     in_ready, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_identity;
        logic early;
        load_cfg(20'hFFFFF);
        checks++;
        if (cfg_loaded !== 1'b1) begin
            errors++;
            $display("FAIL cfg_loaded: got %b required 1", cfg_loaded);
        end
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = ID;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL id_in_ready: got %b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        early = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            if (out_valid) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid seen before 5th cycle, required later");
        end
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== ID) begin
            errors++;
            $display("FAIL id_out: ov=%b data=%h required 1 %h", out_valid, out_data, ID);
        end
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL id_no_dup: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_swaps;
        logic [19:0] cf  [4] = '{20'hFFFFE, 20'hFFFEF, 20'hFFFEE, 20'h7BDEF};
        logic [63:0] exp [4] = '{SW01, SW01, ID, PAIR};
        logic [63:0] q;
        logic        ok;
        for (int i = 0; i < 4; i++) begin
            load_cfg(cf[i]);
            xfer(ID, q, ok);
            checks++;
            if (!ok || q !== exp[i]) begin
                errors++;
                $display("FAIL swap cfg=%h: ok=%b got %h required %h", cf[i], ok, q, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        hold;
        logic [63:0] held;
        int sent, got, cyc;
        load_cfg(20'hFFFFF);
        sent = 0; got = 0; cyc = 0; hold = 1'b0; held = '0;
        while (got < 16 && cyc < 200) begin
            @(negedge clk);
            out_ready = pat[cyc % 4];
            in_valid  = (sent < 16);
            in_data   = wd(sent);
            #1;
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++;
                    $display("FAIL stall_hold: ov=%b data=%h required 1 %h",
                             out_valid, out_data, held);
                end
            end
            hold = out_valid && !out_ready;
            held = out_data;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== wd(got)) begin
                    errors++;
                    $display("FAIL b2b_word %0d: got %h required %h", got, out_data, wd(got));
                end
                got++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 16 || sent != 16) begin
            errors++;
            $display("FAIL b2b_count: sent=%0d got=%0d required 16 16", sent, got);
        end
    endtask

    task automatic test_cfg_drain;
        logic        bad_r, bad_i;
        logic [63:0] q;
        logic        ok;
        int got, n;
        load_cfg(20'hFFFFF);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = wd(20 + k);
            @(posedge clk);
        end
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_state = 20'h7BDEF;
        in_data   = wd(30);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_in_ready: got %b required 0", in_ready);
        end
        got = 0; n = 0; bad_r = 1'b0; bad_i = 1'b0;
        while (got < 3 && n < 20) begin
            if (cfg_ready) bad_r = 1'b1;
            if (in_ready) bad_i = 1'b1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== wd(20 + got)) begin
                    errors++;
                    $display("FAIL drain_word %0d: got %h required %h",
                             got, out_data, wd(20 + got));
                end
                got++;
            end
            if (got < 3) begin
                @(negedge clk); #1;
            end
            n++;
        end
        checks++;
        if (bad_r || bad_i || got != 3) begin
            errors++;
            $display("FAIL drain_block: cfg_ready_seen=%b in_ready_seen=%b got=%0d required 0 0 3",
                     bad_r, bad_i, got);
        end
        @(negedge clk); #1;
        checks++;
        if (cfg_ready !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_accept: cfg_ready=%b in_ready=%b required 1 0", cfg_ready, in_ready);
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        xfer(ID, q, ok);
        checks++;
        if (!ok || q !== PAIR) begin
            errors++;
            $display("FAIL drain_newcfg: ok=%b got %h required %h", ok, q, PAIR);
        end
    endtask

    task automatic test_reset_midstream;
        logic        seen;
        logic [63:0] q;
        logic        ok;
        load_cfg(20'hFFFFF);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = wd(40 + k);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        areset   = 1'b1;
        @(posedge clk); #1;
        areset   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || cfg_loaded !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: ov=%b cl=%b ir=%b required 0 0 0",
                     out_valid, cfg_loaded, in_ready);
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_output: out_valid seen=%b required 0", seen);
        end
        in_valid = 1'b0;
        load_cfg(20'hFFFFF);
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after_cfg: out_valid=%b required 0", out_valid);
        end
        xfer(SW01, q, ok);
        checks++;
        if (!ok || q !== SW01) begin
            errors++;
            $display("FAIL midrst_resume: ok=%b got %h required %h", ok, q, SW01);
        end
    endtask

    task automatic test_random;
        logic [19:0] c;
        logic [63:0] exp;
        logic [63:0] sb [$];
        int sent, got, cyc;
        for (int t = 0; t < 20; t++) begin
            c = 20'($urandom());
            out_ready = 1'b1;
            load_cfg(c);
            sent = 0; got = 0; cyc = 0;
            while (got < 50 && cyc < 2000) begin
                @(negedge clk);
                in_valid  = (sent < 50) && ($urandom_range(3) != 0);
                in_data   = {$urandom(), $urandom()};
                out_ready = ($urandom_range(3) != 0);
                #1;
                if (in_valid && in_ready) begin
                    sb.push_back(route(c, in_data));
                    sent++;
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL rnd_extra cfg=%h: unexpected word %h", c, out_data);
                    end else begin
                        exp = sb.pop_front();
                        if (out_data !== exp) begin
                            errors++;
                            $display("FAIL rnd_word cfg=%h: got %h required %h", c, out_data, exp);
                        end
                    end
                    got++;
                end
                cyc++;
            end
            in_valid = 1'b0;
            checks++;
            if (got != 50 || sb.size() != 0) begin
                errors++;
                $display("FAIL rnd_count cfg=%h: got=%0d left=%0d required 50 0", c, got, sb.size());
            end
            sb.delete();
        end
    endtask

    initial begin
        areset    = 1'b1;
        cfg_valid = 1'b0;
        cfg_state = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset;
        test_identity;
        test_swaps;
        test_back_to_back;
        test_cfg_drain;
        test_reset_midstream;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
